// File: rtl/trg_pkg.sv
// trg_pkg: shared state type, trigger bit map and emission priority for the trigger sequencer.
package trg_pkg;
  typedef enum logic [1:0] {IDLE, CAL_WAIT, DEAD} state_t;
  localparam int TRG_W = 5;
  localparam int TRG_ROCRES = 0;
  localparam int TRG_TRIG = 1;
  localparam int TRG_CAL = 2;
  localparam int TRG_TBMRES = 3;
  localparam int TRG_SYNC = 4;
  localparam logic [TRG_W-1:0] TRG_RESETS = TRG_W'((1 << TRG_TBMRES) | (1 << TRG_ROCRES));
  localparam logic [TRG_W-1:0] TRG_AUTO = TRG_W'(1 << TRG_TRIG);
  function automatic logic [TRG_W-1:0] trg_pick(input logic [TRG_W-1:0] req);
    logic [TRG_W-1:0] r;
    r = '0;
    if (req[TRG_TBMRES]) r[TRG_TBMRES] = 1'b1;
    else if (req[TRG_ROCRES]) r[TRG_ROCRES] = 1'b1;
    else if (req[TRG_CAL]) r[TRG_CAL] = 1'b1;
    else if (req[TRG_TRIG]) r[TRG_TRIG] = 1'b1;
    else if (req[TRG_SYNC]) r[TRG_SYNC] = 1'b1;
    return r;
  endfunction
  function automatic logic [2:0] trg_popcount(input logic [TRG_W-1:0] v);
    return 3'($countones(v));
  endfunction
endpackage

// File: rtl/tick_downcounter.sv
// tick_downcounter: 8-bit interval counter, load or decrement on clock enable, stops at zero.
module tick_downcounter (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       zero
);
  logic [7:0] count;
  assign zero = count == '0;
  always_ff @(posedge clk) begin
    if (reset) count <= '0;
    else if (en) count <= load ? load_val : zero ? count : count - 8'd1;
  end
endmodule

// File: rtl/trigger_sequencer.sv
// trigger_sequencer: arbitrates trigger requests per tick, enforces dead time and cal-to-trigger delay.
module trigger_sequencer
  import trg_pkg::*;
#(
  parameter int CNT_WIDTH = 32,
  parameter int LOST_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sync,
  input  logic [TRG_W-1:0]      trg_in,
  input  logic [7:0]            deadtime,
  input  logic [7:0]            cal_delay,
  input  logic                  count_clear,
  output logic [TRG_W-1:0]      trg_out,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  trigger_count,
  output logic [LOST_WIDTH-1:0] lost_count
);
  state_t state_q, state_d;
  logic [TRG_W-1:0] emit;
  logic open, abort, accepted, load, cnt_zero;
  logic [7:0] load_val;
  logic [2:0] lost_inc;
  logic [LOST_WIDTH+2:0] lost_sum;
  logic [LOST_WIDTH-1:0] lost_next;
  tick_downcounter u_interval (
    .clk(clk),
    .reset(reset),
    .en(sync),
    .load(load),
    .load_val(load_val),
    .zero(cnt_zero)
  );
  // an expired DEAD interval behaves exactly like IDLE on the same tick
  always_comb begin
    open = state_q == IDLE || (state_q == DEAD && cnt_zero);
    abort = !open && |(trg_in & TRG_RESETS);
    emit = open ? trg_pick(trg_in) : abort ? trg_pick(trg_in & TRG_RESETS) :
           (state_q == CAL_WAIT && cnt_zero) ? TRG_AUTO : '0;
    accepted = open ? |trg_in : abort;
    lost_inc = trg_popcount(trg_in) - 3'(accepted);
    load = emit[TRG_CAL] | emit[TRG_TRIG] | emit[TRG_ROCRES] | emit[TRG_TBMRES];
    load_val = emit[TRG_CAL] ? cal_delay : deadtime;
    state_d = emit[TRG_CAL] ? CAL_WAIT : load ? (deadtime == '0 ? IDLE : DEAD) :
              open ? IDLE : state_q;
  end
  assign lost_sum = (LOST_WIDTH+3)'(lost_count) + (LOST_WIDTH+3)'(lost_inc);
  assign lost_next = |lost_sum[LOST_WIDTH+2:LOST_WIDTH] ? '1 : lost_sum[LOST_WIDTH-1:0];
  assign busy = state_q != IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      trg_out <= '0;
    end else if (sync) begin
      state_q <= state_d;
      trg_out <= emit;
    end
  end
  always_ff @(posedge clk) begin
    if (reset || count_clear) begin
      trigger_count <= '0;
      lost_count <= '0;
    end else if (sync) begin
      trigger_count <= trigger_count + CNT_WIDTH'(emit[TRG_TRIG]);
      lost_count <= lost_next;
    end
  end
endmodule
